odd_number_stream_controller: RTL and testbench

Upstream sequencer for `odd_number_analyzer`. It accepts WIDTH-bit numbers over a valid/ready handshake and presents each number's LSB to the analyzer. It drives the analyzer's `enable` through one full analysis, then returns the verdict on a one-cycle result strobe. It keeps saturating odd/even tallies and flags analyzer timeouts and verdict mismatches.

---
 rtl/odd_number_stream_controller_if.sv | 24 ++
 rtl/odd_number_stream_controller.sv | 152 +++++++++++++++
 tb/tb_odd_number_stream_controller.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/odd_number_stream_controller_if.sv
// Upstream number stream and result strobe between a producer and the
// odd-number stream controller.
interface odd_number_stream_controller_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             res_valid;
  logic             res_is_odd;
  logic [WIDTH-1:0] res_data;

  // Producer side: offers numbers, consumes verdicts.
  modport master (
    output in_valid, in_data,
    input  in_ready, res_valid, res_is_odd, res_data
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, res_valid, res_is_odd, res_data
  );
endinterface

// File: rtl/odd_number_stream_controller.sv
// Sequencer in front of odd_number_analyzer: captures one number, presents
// its LSB, runs the analyzer through one analysis, strobes the verdict and
// keeps saturating odd/even tallies plus sticky timeout/mismatch flags.
module odd_number_stream_controller #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  odd_number_stream_controller_if.slave stream,
  input  logic                 clear,
  output logic                 an_number,
  output logic                 an_enable,
  input  logic                 an_out_ready,
  input  logic                 an_is_odd,
  output logic [COUNT_W-1:0]   odd_count,
  output logic [COUNT_W-1:0]   even_count,
  output logic                 timeout_err,
  output logic                 mismatch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_RESULT,
    S_RELEASE
  } state_t;

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  // Timer value during the last permitted cycle of RUN or RELEASE.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t             state;
  state_t             next_state;
  logic [TIMER_W-1:0] timer;
  logic [WIDTH-1:0]   data_reg;
  logic               res_valid_r;
  logic               res_is_odd_r;
  logic               timed_out;   // current verdict came from a timeout, not the analyzer
  logic               run_timeout;
  logic               rel_timeout;

  assign stream.in_ready   = (state == S_IDLE);
  assign stream.res_valid  = res_valid_r;
  assign stream.res_is_odd = res_is_odd_r;
  // data_reg only changes at capture, so it is stable through RESULT.
  assign stream.res_data   = data_reg;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode and timeout detection.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    next_state  = state;
    run_timeout = 1'b0;
    rel_timeout = 1'b0;
    case (state)
      S_IDLE:   if (stream.in_valid) next_state = S_SETUP;
      S_SETUP:  next_state = S_RUN;
      S_RUN: begin
        // A response in the final cycle still wins over the timeout.
        if (an_out_ready) begin
          next_state = S_RESULT;
        end else if (timer == TIMER_LAST) begin
          next_state  = S_RESULT;
          run_timeout = 1'b1;
        end
      end
      S_RESULT: next_state = S_RELEASE;
      S_RELEASE: begin
        if (!an_out_ready) begin
          next_state = S_IDLE;
        end else if (timer == TIMER_LAST) begin
          next_state  = S_IDLE;
          rel_timeout = 1'b1;
        end
      end
      default:  next_state = S_IDLE;
    endcase
  end

  // Datapath: capture, analyzer drive, timer and result strobe.
  // NOTE: reset is synchronous and covers every flop here, so a reset in
  // the middle of an analysis drops it without a strobe or tally update.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_reg     <= '0;
      an_number    <= 1'b0;
      an_enable    <= 1'b0;
      timer        <= '0;
      res_valid_r  <= 1'b0;
      res_is_odd_r <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      // Registered from next_state so enable drops on the edge the strobe rises.
      an_enable   <= (next_state == S_RUN);
      res_valid_r <= (next_state == S_RESULT);

      if (state == S_IDLE && stream.in_valid) begin
        data_reg  <= stream.in_data;
        an_number <= stream.in_data[0];
      end

      // The timer idles at zero outside RUN/RELEASE; passing through
      // RESULT restarts it for RELEASE.
      if (state == S_RUN || state == S_RELEASE) timer <= timer + TIMER_W'(1);
      else                                      timer <= '0;

      if (state == S_RUN) begin
        if (an_out_ready) begin
          res_is_odd_r <= an_is_odd;
          timed_out    <= 1'b0;
        end else if (run_timeout) begin
          res_is_odd_r <= 1'b0;
          timed_out    <= 1'b1;
        end
      end
    end
  end

  // Tallies and sticky error flags; clear overrides any same-cycle update.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      odd_count    <= '0;
      even_count   <= '0;
      timeout_err  <= 1'b0;
      mismatch_err <= 1'b0;
    end else begin
      if (run_timeout || rel_timeout) timeout_err <= 1'b1;
      // A timed-out verdict is synthetic: it is neither counted nor
      // compared against the analyzer.
      if (state == S_RESULT && !timed_out) begin
        if (res_is_odd_r) begin
          if (odd_count != '1) odd_count <= odd_count + COUNT_W'(1);
        end else begin
          if (even_count != '1) even_count <= even_count + COUNT_W'(1);
        end
        if (an_is_odd != data_reg[0]) mismatch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_odd_number_stream_controller.sv
// Self-checking bench for odd_number_stream_controller with a behavioural
// two-cycle analyzer model and a transaction-level reference model.
module tb_odd_number_stream_controller;
  localparam int WIDTH   = 8;
  localparam int COUNT_W = 2;
  localparam int TIMEOUT = 15;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic an_number, an_enable, an_out_ready, an_is_odd;
  logic [COUNT_W-1:0] odd_count, even_count;
  logic timeout_err, mismatch_err;

  odd_number_stream_controller_if #(.WIDTH(WIDTH)) sif ();

  odd_number_stream_controller #(
    .WIDTH(WIDTH), .COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .stream(sif.slave), .clear(clear),
    .an_number(an_number), .an_enable(an_enable),
    .an_out_ready(an_out_ready), .an_is_odd(an_is_odd),
    .odd_count(odd_count), .even_count(even_count),
    .timeout_err(timeout_err), .mismatch_err(mismatch_err)
  );

  always #5 clock = ~clock;

  // Analyzer model: samples in_number while disabled, then takes two
  // enabled cycles (S0 -> S1 -> verdict) and holds out_ready until disabled.
  logic [1:0] an_st  = 2'd0;
  logic       an_num = 1'b0;
  bit         an_stuck  = 1'b0;   // never answers
  bit         an_invert = 1'b0;   // answers with the wrong parity
  always @(posedge clock) begin
    if (an_enable !== 1'b1) begin
      an_st  <= 2'd0;
      an_num <= an_number;
    end else if (an_st < 2'd2) begin
      an_st <= an_st + 2'd1;
    end
  end
  assign an_out_ready = (an_st == 2'd2) && !an_stuck;
  assign an_is_odd    = an_num ^ an_invert;

  // Reference model state.
  int m_odd, m_even;
  bit m_to, m_mm;
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_clear();
    m_odd = 0; m_even = 0; m_to = 0; m_mm = 0;
  endfunction

  // Expected verdict for one transaction; updates tallies and flags.
  function automatic bit model_txn(input logic [7:0] d, input bit clr_same_cycle);
    bit v;
    v = an_stuck ? 1'b0 : (d[0] ^ an_invert);
    if (an_stuck) m_to = 1;
    else begin
      if (v) m_odd  = (m_odd  < CMAX) ? m_odd  + 1 : CMAX;
      else   m_even = (m_even < CMAX) ? m_even + 1 : CMAX;
      if (an_invert) m_mm = 1;
    end
    if (clr_same_cycle) model_clear();
    return v;
  endfunction

  // Drives one number and observes the resulting activity, counted in
  // edges after the accept edge.
  task automatic run_number(input logic [7:0] d, input bit hold, input bit clr_at_res,
                            output int lat, output logic r_odd, output logic [7:0] r_data,
                            output int pulses, output int rdy, output int en_bad);
    int w;
    bit exp_en;
    lat = -1; r_odd = 1'b0; r_data = '0; pulses = 0; rdy = -1; en_bad = 0;
    @(negedge clock);
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    w = 0;
    while (sif.in_ready !== 1'b1 && w < 50) begin @(negedge clock); w++; end
    @(posedge clock);
    #1;
    if (hold) sif.in_data = ~d;  // busy-time junk that must be ignored
    else begin sif.in_valid = 1'b0; sif.in_data = 8'($urandom); end
    if (an_enable !== 1'b0) en_bad++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      clear = 1'b0;
      if (sif.res_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k; r_odd = sif.res_is_odd; r_data = sif.res_data;
          if (clr_at_res) clear = 1'b1;
        end
      end
      exp_en = (lat < 0);
      if (an_enable !== exp_en) en_bad++;
      if (sif.in_ready === 1'b1) begin
        rdy = k;
        break;
      end
    end
    sif.in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_clear();
    n_checks++; if (sif.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", sif.in_ready); else n_pass++;
    n_checks++; if (an_enable !== 1'b0) $display("FAIL reset_an_enable: got %b want 0", an_enable); else n_pass++;
    n_checks++; if (an_number !== 1'b0) $display("FAIL reset_an_number: got %b want 0", an_number); else n_pass++;
    n_checks++; if ({sif.res_valid, sif.res_is_odd} !== 2'b00) $display("FAIL reset_res_flags: got %b want 00", {sif.res_valid, sif.res_is_odd}); else n_pass++;
    n_checks++; if (sif.res_data !== 8'h00) $display("FAIL reset_res_data: got %h want 00", sif.res_data); else n_pass++;
    n_checks++; if ({odd_count, even_count} !== '0) $display("FAIL reset_counts: got %0d/%0d want 0/0", odd_count, even_count); else n_pass++;
    n_checks++; if ({timeout_err, mismatch_err} !== 2'b00) $display("FAIL reset_errors: got %b want 00", {timeout_err, mismatch_err}); else n_pass++;
  endtask

  task automatic test_single();
    int lat, pulses, rdy, en_bad; logic r_odd; logic [7:0] r_data; bit v;
    v = model_txn(8'h03, 0);
    run_number(8'h03, 1'b1, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
    n_checks++; if (lat !== 4) $display("FAIL single_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL single_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (r_odd !== v) $display("FAIL single_is_odd: got %b want %b", r_odd, v); else n_pass++;
    n_checks++; if (r_data !== 8'h03) $display("FAIL single_data: got %h want 03", r_data); else n_pass++;
    n_checks++; if (rdy !== 6) $display("FAIL single_ready: got %0d want 6", rdy); else n_pass++;
    n_checks++; if (en_bad !== 0) $display("FAIL single_enable: got %0d bad cycles want 0", en_bad); else n_pass++;
    n_checks++; if (an_number !== 1'b1) $display("FAIL single_an_number: got %b want 1", an_number); else n_pass++;
    n_checks++; if (odd_count !== COUNT_W'(m_odd) || even_count !== COUNT_W'(m_even))
      $display("FAIL single_counts: got %0d/%0d want %0d/%0d", odd_count, even_count, m_odd, m_even); else n_pass++;
  endtask

  task automatic test_stream();
    logic [7:0] nums [4];
    int lat, pulses, rdy, en_bad; logic r_odd; logic [7:0] r_data; bit v;
    nums = '{8'h02, 8'h07, 8'hFF, 8'h10};
    pulse_clear();
    foreach (nums[i]) begin
      v = model_txn(nums[i], 0);
      run_number(nums[i], 1'b0, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
      n_checks++; if (r_odd !== v || r_data !== nums[i] || lat !== 4 || rdy !== 6)
        $display("FAIL stream_%0d: got odd=%b data=%h lat=%0d rdy=%0d want odd=%b data=%h lat=4 rdy=6",
                 i, r_odd, r_data, lat, rdy, v, nums[i]); else n_pass++;
      n_checks++; if (en_bad !== 0 || pulses !== 1)
        $display("FAIL stream_enable_%0d: got bad=%0d pulses=%0d want 0/1", i, en_bad, pulses); else n_pass++;
    end
    n_checks++; if (odd_count !== 2'd2 || even_count !== 2'd2)
      $display("FAIL stream_counts: got %0d/%0d want 2/2", odd_count, even_count); else n_pass++;
    n_checks++; if ({timeout_err, mismatch_err} !== 2'b00)
      $display("FAIL stream_errors: got %b want 00", {timeout_err, mismatch_err}); else n_pass++;
  endtask

  task automatic test_random();
    int lat, pulses, rdy, en_bad; logic r_odd; logic [7:0] r_data; bit v, hold;
    logic [7:0] d;
    pulse_clear();
    for (int t = 0; t < 24; t++) begin
      d = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      an_invert = ($urandom_range(0, 3) == 0);
      v = model_txn(d, 0);
      run_number(d, hold, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
      n_checks++; if (r_odd !== v || r_data !== d || lat !== 4 || rdy !== 6 || pulses !== 1 || en_bad !== 0)
        $display("FAIL random_%0d: got odd=%b data=%h lat=%0d rdy=%0d pulses=%0d enbad=%0d want odd=%b data=%h 4/6/1/0",
                 t, r_odd, r_data, lat, rdy, pulses, en_bad, v, d); else n_pass++;
      n_checks++; if (an_number !== d[0]) $display("FAIL random_an_number_%0d: got %b want %b", t, an_number, d[0]); else n_pass++;
      n_checks++; if (odd_count !== COUNT_W'(m_odd) || even_count !== COUNT_W'(m_even) || mismatch_err !== m_mm)
        $display("FAIL random_tally_%0d: got %0d/%0d mm=%b want %0d/%0d mm=%b",
                 t, odd_count, even_count, mismatch_err, m_odd, m_even, m_mm); else n_pass++;
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    an_invert = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, pulses, rdy, en_bad; logic r_odd; logic [7:0] r_data; bit v;
    pulse_clear();
    an_stuck = 1'b1;
    v = model_txn(8'h05, 0);
    run_number(8'h05, 1'b0, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
    an_stuck = 1'b0;
    n_checks++; if (lat !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d want %0d", lat, TIMEOUT + 1); else n_pass++;
    n_checks++; if (r_odd !== v || r_data !== 8'h05) $display("FAIL timeout_result: got %b/%h want %b/05", r_odd, r_data, v); else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_flag: got %b want 1", timeout_err); else n_pass++;
    n_checks++; if (odd_count !== 2'd0 || even_count !== 2'd0) $display("FAIL timeout_counts: got %0d/%0d want 0/0", odd_count, even_count); else n_pass++;
    n_checks++; if (rdy !== TIMEOUT + 3 || pulses !== 1 || en_bad !== 0)
      $display("FAIL timeout_idle: got rdy=%0d pulses=%0d enbad=%0d want %0d/1/0", rdy, pulses, en_bad, TIMEOUT + 3); else n_pass++;
  endtask

  task automatic test_mismatch_clear();
    int lat, pulses, rdy, en_bad; logic r_odd; logic [7:0] r_data; bit v;
    pulse_clear();
    an_invert = 1'b1;
    v = model_txn(8'h05, 0);
    run_number(8'h05, 1'b0, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
    an_invert = 1'b0;
    n_checks++; if (r_odd !== 1'b0 || r_odd !== v) $display("FAIL mismatch_verdict: got %b want 0", r_odd); else n_pass++;
    n_checks++; if (mismatch_err !== 1'b1) $display("FAIL mismatch_flag: got %b want 1", mismatch_err); else n_pass++;
    n_checks++; if (even_count !== 2'd1 || odd_count !== 2'd0) $display("FAIL mismatch_counts: got %0d/%0d want 0/1", odd_count, even_count); else n_pass++;
    pulse_clear();
    n_checks++; if ({odd_count, even_count, timeout_err, mismatch_err} !== '0)
      $display("FAIL clear_all: got %0d/%0d to=%b mm=%b want all 0", odd_count, even_count, timeout_err, mismatch_err); else n_pass++;
  endtask

  task automatic test_saturation_clear();
    int lat, pulses, rdy, en_bad; logic r_odd; logic [7:0] r_data; bit v;
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      v = model_txn(8'(2 * i + 1), 0);
      run_number(8'(2 * i + 1), 1'b0, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
      n_checks++; if (odd_count !== COUNT_W'(m_odd))
        $display("FAIL saturate_%0d: got %0d want %0d", i, odd_count, m_odd); else n_pass++;
    end
    n_checks++; if (odd_count !== 2'd3) $display("FAIL saturate_final: got %0d want 3", odd_count); else n_pass++;
    v = model_txn(8'h21, 1);
    run_number(8'h21, 1'b0, 1'b1, lat, r_odd, r_data, pulses, rdy, en_bad);
    n_checks++; if (odd_count !== 2'd0 || even_count !== 2'd0)
      $display("FAIL clear_vs_count: got %0d/%0d want 0/0", odd_count, even_count); else n_pass++;
    an_invert = 1'b1;
    v = model_txn(8'h07, 1);
    run_number(8'h07, 1'b0, 1'b1, lat, r_odd, r_data, pulses, rdy, en_bad);
    an_invert = 1'b0;
    n_checks++; if (mismatch_err !== 1'b0 || even_count !== 2'd0)
      $display("FAIL clear_vs_flag: got mm=%b even=%0d want 0/0", mismatch_err, even_count); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses, rdy, en_bad, seen; logic r_odd; logic [7:0] r_data; bit v;
    v = model_txn(8'h01, 0);  // leave a nonzero tally for reset to wipe
    run_number(8'h01, 1'b0, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
    @(negedge clock);
    sif.in_valid = 1'b1; sif.in_data = 8'h0B;
    @(posedge clock);          // accept
    #1 sif.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (an_enable !== 1'b1) $display("FAIL midrun_running: got %b want 1", an_enable); else n_pass++;
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_clear();
    n_checks++; if (an_enable !== 1'b0 || sif.res_valid !== 1'b0)
      $display("FAIL midrun_abort: got en=%b rv=%b want 0/0", an_enable, sif.res_valid); else n_pass++;
    @(negedge clock); reset = 1'b0;
    seen = 0;
    repeat (8) begin @(posedge clock); #1; if (sif.res_valid === 1'b1) seen++; end
    n_checks++; if (seen !== 0) $display("FAIL midrun_no_strobe: got %0d strobes want 0", seen); else n_pass++;
    n_checks++; if (odd_count !== 2'd0 || even_count !== 2'd0)
      $display("FAIL midrun_counts: got %0d/%0d want 0/0", odd_count, even_count); else n_pass++;
    v = model_txn(8'h09, 0);
    run_number(8'h09, 1'b0, 1'b0, lat, r_odd, r_data, pulses, rdy, en_bad);
    n_checks++; if (lat !== 4 || r_odd !== v || r_data !== 8'h09 || odd_count !== COUNT_W'(m_odd))
      $display("FAIL midrun_recover: got lat=%0d odd=%b data=%h cnt=%0d want 4/%b/09/%0d",
               lat, r_odd, r_data, odd_count, v, m_odd); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    test_reset();
    test_single();
    test_stream();
    test_random();
    test_timeout();
    test_mismatch_clear();
    test_saturation_clear();
    test_reset_mid_run();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
